// File: rtl/fetch_queue.sv
//==============================================================================
// Module   : fetch_queue
// Summary  : Instruction fetch unit with a small in-order queue. A PC register
//            addresses a combinational ROM, and each fetched {pc, inst} pair is
//            queued for the decode stage. A flush clears the queue and redirects
//            the PC.
// Options  : define FETCH_QUEUE_PERF_EN to add the stall_cnt_o counter port.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_queue #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INST_W   = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [INST_W-1:0] rom_data_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic              rom_ce_o,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] flush_pc_i,
   input  logic              id_ready_i,
   output logic              id_valid_o,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [INST_W-1:0] id_inst_o
`ifdef FETCH_QUEUE_PERF_EN
   ,
   output logic [31:0]       stall_cnt_o
`endif
);

   localparam int unsigned       c_ptr_w   = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(PC_STEP);
   localparam logic [c_ptr_w:0]  c_depth   = (c_ptr_w + 1)'(DEPTH);
   localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
   localparam logic [c_ptr_w:0]  c_cnt_one = (c_ptr_w + 1)'(1);

   logic [ADDR_W-1:0]  r_pc;
   logic               r_ce_q;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w:0]   r_count;
   logic [ADDR_W-1:0]  r_pc_mem   [DEPTH];
   logic [INST_W-1:0]  r_inst_mem [DEPTH];

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   // Fullness is judged on the occupancy at the start of the cycle, so a pop
   // in the same cycle never frees a slot for a push.
   assign w_full  = (r_count == c_depth);
   assign w_empty = (r_count == '0);

   assign rom_addr_o = r_pc;
   assign rom_ce_o   = r_ce_q & ~w_full & ~flush_i;
   assign id_valid_o = ~w_empty & ~flush_i;
   assign id_pc_o    = w_empty ? '0 : r_pc_mem[r_rd_ptr];
   assign id_inst_o  = w_empty ? '0 : r_inst_mem[r_rd_ptr];

   // Both qualifiers already exclude flush, so flush needs no extra gating here.
   assign w_push = rom_ce_o;
   assign w_pop  = id_valid_o & id_ready_i;

   // PC, enable flop, pointers and occupancy; flush overrides every other event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc     <= RESET_PC;
         r_ce_q   <= 1'b0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_ce_q <= 1'b1;
         if (flush_i) begin
            r_pc     <= flush_pc_i;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_pc     <= r_pc + c_pc_step;
               r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + c_cnt_one;
               2'b01:   r_count <= r_count - c_cnt_one;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Queue storage; the captured word pairs with the address that fetched it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_pc_mem[i]   <= '0;
            r_inst_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_pc_mem[r_wr_ptr]   <= r_pc;
         r_inst_mem[r_wr_ptr] <= rom_data_i;
      end
   end

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] r_stall_cnt;

   // Count cycles where fetch is enabled but blocked by a full queue; saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (r_ce_q & w_full & ~flush_i & (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
//==============================================================================
// Module   : tb_fetch_queue
// Summary  : Self-checking bench for fetch_queue (DEPTH=4, PC_STEP=4, ROM word
//            = addr ^ 0xA5A5_0000) using a queue-based reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_queue;

   logic        clk;
   logic        rst;
   logic [31:0] rom_data;
   logic [31:0] rom_addr;
   logic        rom_ce;
   logic        flush;
   logic [31:0] flush_pc;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;

   logic [31:0] w_rom_data;
   logic [31:0] w_rom_addr;
   logic        w_rom_ce;
   logic        w_id_valid;
   logic [31:0] w_id_pc;
   logic [31:0] w_id_inst;

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] w_stall_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // reference model: queue of PCs in push order; instruction derives from PC
   logic [31:0] mq[$];
   logic [31:0] m_pc;
   logic        m_ce;
   logic [31:0] m_stall;

   assign rom_data   = rom_addr ^ 32'hA5A5_0000;
   assign w_rom_data = w_rom_addr ^ 32'hA5A5_0000;

   fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .rom_data_i (rom_data),
      .rom_addr_o (rom_addr),
      .rom_ce_o   (rom_ce),
      .flush_i    (flush),
      .flush_pc_i (flush_pc),
      .id_ready_i (id_ready),
      .id_valid_o (id_valid),
      .id_pc_o    (id_pc),
      .id_inst_o  (id_inst)
`ifdef FETCH_QUEUE_PERF_EN
      ,
      .stall_cnt_o(stall_cnt)
`endif
   );

   fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
      .clk        (clk),
      .rst        (rst),
      .rom_data_i (w_rom_data),
      .rom_addr_o (w_rom_addr),
      .rom_ce_o   (w_rom_ce),
      .flush_i    (1'b0),
      .flush_pc_i (32'h0),
      .id_ready_i (1'b1),
      .id_valid_o (w_id_valid),
      .id_pc_o    (w_id_pc),
      .id_inst_o  (w_id_inst)
`ifdef FETCH_QUEUE_PERF_EN
      ,
      .stall_cnt_o(w_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance the model by one clock edge using the current inputs, then step the DUT
   task automatic model_tick();
      bit full, ce, valid;
      full  = (mq.size() == 4);
      ce    = m_ce && !full && !flush;
      valid = (mq.size() != 0) && !flush;
      if (m_ce && full && !flush && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (flush) begin
         mq.delete();
         m_pc = flush_pc;
      end else begin
         if (valid && id_ready) void'(mq.pop_front());
         if (ce) begin
            mq.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end
      m_ce = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // hold reset over one edge, then release just after the edge
   task automatic do_reset();
      rst = 1'b1;
      flush = 1'b0;
      flush_pc = 32'h0;
      id_ready = 1'b0;
      mq.delete();
      m_pc = 32'h0;
      m_ce = 1'b0;
      m_stall = 32'h0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      flush = 1'b0;
      flush_pc = 32'h0;
      id_ready = 1'b0;
      #1;
      checks += 5;
      if (rom_ce !== 1'b0) begin errors++; $display("FAIL reset.rom_ce got=%b exp=0", rom_ce); end
      if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset.rom_addr got=%h exp=00000000", rom_addr); end
      if (id_valid !== 1'b0) begin errors++; $display("FAIL reset.id_valid got=%b exp=0", id_valid); end
      if (id_pc !== 32'h0) begin errors++; $display("FAIL reset.id_pc got=%h exp=00000000", id_pc); end
      if (id_inst !== 32'h0) begin errors++; $display("FAIL reset.id_inst got=%h exp=00000000", id_inst); end
      checks++;
      if (w_rom_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset.wrap_addr got=%h exp=fffffffc", w_rom_addr); end
   endtask

   task automatic test_streaming();
      logic e_ce, e_valid;
      logic [31:0] e_pc, e_inst;
      do_reset();
      id_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         e_ce    = m_ce && (mq.size() != 4) && !flush;
         e_valid = (mq.size() != 0) && !flush;
         e_pc    = (mq.size() != 0) ? mq[0] : 32'h0;
         e_inst  = (mq.size() != 0) ? (mq[0] ^ 32'hA5A5_0000) : 32'h0;
         checks += 5;
         if (rom_ce !== e_ce) begin errors++; $display("FAIL stream.rom_ce cyc=%0d got=%b exp=%b", c, rom_ce, e_ce); end
         if (rom_addr !== m_pc) begin errors++; $display("FAIL stream.rom_addr cyc=%0d got=%h exp=%h", c, rom_addr, m_pc); end
         if (id_valid !== e_valid) begin errors++; $display("FAIL stream.id_valid cyc=%0d got=%b exp=%b", c, id_valid, e_valid); end
         if (id_pc !== e_pc) begin errors++; $display("FAIL stream.id_pc cyc=%0d got=%h exp=%h", c, id_pc, e_pc); end
         if (id_inst !== e_inst) begin errors++; $display("FAIL stream.id_inst cyc=%0d got=%h exp=%h", c, id_inst, e_inst); end
         model_tick();
      end
   endtask

   task automatic test_fill_stall();
      logic e_ce, e_valid;
      logic [31:0] e_pc;
      do_reset();
      id_ready = 1'b0;
      for (int c = 0; c < 7; c++) model_tick();
      #1;
      checks += 3;
      if (rom_ce !== 1'b0) begin errors++; $display("FAIL fill.rom_ce got=%b exp=0", rom_ce); end
      if (rom_addr !== 32'h10) begin errors++; $display("FAIL fill.rom_addr got=%h exp=00000010", rom_addr); end
      if (id_pc !== 32'h0) begin errors++; $display("FAIL fill.head_pc got=%h exp=00000000", id_pc); end
`ifdef FETCH_QUEUE_PERF_EN
      checks++;
      if (stall_cnt !== m_stall) begin errors++; $display("FAIL fill.stall_cnt got=%0d exp=%0d", stall_cnt, m_stall); end
`endif
      id_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         #1;
         e_ce    = m_ce && (mq.size() != 4) && !flush;
         e_valid = (mq.size() != 0) && !flush;
         e_pc    = (mq.size() != 0) ? mq[0] : 32'h0;
         checks += 4;
         if (rom_ce !== e_ce) begin errors++; $display("FAIL drain.rom_ce cyc=%0d got=%b exp=%b", c, rom_ce, e_ce); end
         if (rom_addr !== m_pc) begin errors++; $display("FAIL drain.rom_addr cyc=%0d got=%h exp=%h", c, rom_addr, m_pc); end
         if (id_valid !== e_valid) begin errors++; $display("FAIL drain.id_valid cyc=%0d got=%b exp=%b", c, id_valid, e_valid); end
         if (id_pc !== e_pc) begin errors++; $display("FAIL drain.id_pc cyc=%0d got=%h exp=%h", c, id_pc, e_pc); end
`ifdef FETCH_QUEUE_PERF_EN
         checks++;
         if (stall_cnt !== m_stall) begin errors++; $display("FAIL drain.stall_cnt cyc=%0d got=%0d exp=%0d", c, stall_cnt, m_stall); end
`endif
         model_tick();
      end
   endtask

   task automatic test_flush();
      do_reset();
      id_ready = 1'b0;
      for (int c = 0; c < 4; c++) model_tick();
      flush = 1'b1;
      flush_pc = 32'h100;
      #1;
      checks += 2;
      if (id_valid !== 1'b0) begin errors++; $display("FAIL flush.id_valid got=%b exp=0", id_valid); end
      if (rom_ce !== 1'b0) begin errors++; $display("FAIL flush.rom_ce got=%b exp=0", rom_ce); end
      model_tick();
      flush = 1'b0;
      #1;
      checks += 2;
      if (rom_addr !== 32'h100) begin errors++; $display("FAIL flush.rom_addr got=%h exp=00000100", rom_addr); end
      if (id_valid !== 1'b0) begin errors++; $display("FAIL flush.empty got=%b exp=0", id_valid); end
      id_ready = 1'b1;
      model_tick();
      checks += 2;
      if (id_valid !== 1'b1) begin errors++; $display("FAIL flush.first_valid got=%b exp=1", id_valid); end
      if (id_pc !== 32'h100) begin errors++; $display("FAIL flush.first_pc got=%h exp=00000100", id_pc); end
      // back-to-back flushes: the last target wins
      flush = 1'b1;
      flush_pc = 32'h200;
      model_tick();
      flush_pc = 32'h300;
      model_tick();
      flush = 1'b0;
      model_tick();
      checks += 2;
      if (id_pc !== 32'h300) begin errors++; $display("FAIL flush.b2b_pc got=%h exp=00000300", id_pc); end
      if (id_inst !== (32'h300 ^ 32'hA5A5_0000)) begin errors++; $display("FAIL flush.b2b_inst got=%h exp=%h", id_inst, 32'h300 ^ 32'hA5A5_0000); end
   endtask

   task automatic test_full_pop();
      do_reset();
      id_ready = 1'b0;
      for (int c = 0; c < 5; c++) model_tick();
      id_ready = 1'b1;
      #1;
      checks += 3;
      if (rom_ce !== 1'b0) begin errors++; $display("FAIL fullpop.no_push got=%b exp=0", rom_ce); end
      if (id_valid !== 1'b1) begin errors++; $display("FAIL fullpop.valid got=%b exp=1", id_valid); end
      if (id_pc !== 32'h0) begin errors++; $display("FAIL fullpop.head got=%h exp=00000000", id_pc); end
      model_tick();
      checks += 3;
      if (rom_ce !== 1'b1) begin errors++; $display("FAIL fullpop.resume got=%b exp=1", rom_ce); end
      if (rom_addr !== 32'h10) begin errors++; $display("FAIL fullpop.addr got=%h exp=00000010", rom_addr); end
      if (id_pc !== 32'h4) begin errors++; $display("FAIL fullpop.head2 got=%h exp=00000004", id_pc); end
      model_tick();
      checks++;
      if (id_pc !== 32'h8) begin errors++; $display("FAIL fullpop.head3 got=%h exp=00000008", id_pc); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         #1;
         if (c == 1) begin
            checks += 2;
            if (w_rom_ce !== 1'b1) begin errors++; $display("FAIL wrap.rom_ce got=%b exp=1", w_rom_ce); end
            if (w_rom_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap.rom_addr got=%h exp=fffffffc", w_rom_addr); end
         end
         if (c == 2) begin
            checks += 3;
            if (w_id_valid !== 1'b1) begin errors++; $display("FAIL wrap.valid got=%b exp=1", w_id_valid); end
            if (w_id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap.pc0 got=%h exp=fffffffc", w_id_pc); end
            if (w_id_inst !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wrap.inst0 got=%h exp=5a5afffc", w_id_inst); end
         end
         if (c == 3) begin
            checks += 2;
            if (w_id_pc !== 32'h0) begin errors++; $display("FAIL wrap.pc1 got=%h exp=00000000", w_id_pc); end
            if (w_id_inst !== 32'hA5A5_0000) begin errors++; $display("FAIL wrap.inst1 got=%h exp=a5a50000", w_id_inst); end
         end
         model_tick();
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      id_ready = 1'b0;
      for (int c = 0; c < 3; c++) model_tick();
      checks++;
      if (id_valid !== 1'b1) begin errors++; $display("FAIL areset.pre_valid got=%b exp=1", id_valid); end
      #1;
      rst = 1'b1;
      #1;
      checks += 5;
      if (id_valid !== 1'b0) begin errors++; $display("FAIL areset.id_valid got=%b exp=0", id_valid); end
      if (rom_addr !== 32'h0) begin errors++; $display("FAIL areset.rom_addr got=%h exp=00000000", rom_addr); end
      if (rom_ce !== 1'b0) begin errors++; $display("FAIL areset.rom_ce got=%b exp=0", rom_ce); end
      if (id_pc !== 32'h0) begin errors++; $display("FAIL areset.id_pc got=%h exp=00000000", id_pc); end
      if (id_inst !== 32'h0) begin errors++; $display("FAIL areset.id_inst got=%h exp=00000000", id_inst); end
   endtask

   task automatic test_random();
      logic e_ce, e_valid;
      logic [31:0] e_pc, e_inst;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         id_ready = ($urandom_range(0, 9) < 6);
         flush    = ($urandom_range(0, 19) == 0);
         flush_pc = $urandom() & 32'hFFFF_FFFC;
         #1;
         e_ce    = m_ce && (mq.size() != 4) && !flush;
         e_valid = (mq.size() != 0) && !flush;
         e_pc    = (mq.size() != 0) ? mq[0] : 32'h0;
         e_inst  = (mq.size() != 0) ? (mq[0] ^ 32'hA5A5_0000) : 32'h0;
         checks += 5;
         if (rom_ce !== e_ce) begin errors++; $display("FAIL rand.rom_ce cyc=%0d got=%b exp=%b", c, rom_ce, e_ce); end
         if (rom_addr !== m_pc) begin errors++; $display("FAIL rand.rom_addr cyc=%0d got=%h exp=%h", c, rom_addr, m_pc); end
         if (id_valid !== e_valid) begin errors++; $display("FAIL rand.id_valid cyc=%0d got=%b exp=%b", c, id_valid, e_valid); end
         if (id_pc !== e_pc) begin errors++; $display("FAIL rand.id_pc cyc=%0d got=%h exp=%h", c, id_pc, e_pc); end
         if (id_inst !== e_inst) begin errors++; $display("FAIL rand.id_inst cyc=%0d got=%h exp=%h", c, id_inst, e_inst); end
`ifdef FETCH_QUEUE_PERF_EN
         checks++;
         if (stall_cnt !== m_stall) begin errors++; $display("FAIL rand.stall_cnt cyc=%0d got=%0d exp=%0d", c, stall_cnt, m_stall); end
`endif
         model_tick();
      end
      flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_fill_stall();
      test_flush();
      test_full_pop();
      test_wrap();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
